// File: rtl/usr_pkg.sv
// Shared types and helpers for the reversible universal shift register datapath.
package usr_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } rx_state_t;

  localparam int USR_WIDTH_DEFAULT = 4;

  // Bits needed to hold a bit count in the range 0..w.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/usr_serial_receiver_dual_rail_sampler.sv
// Dual-rail bit decoder: passes the true rail and flags strobed bits whose rails agree.
module dual_rail_sampler (
  input  logic sin_en,
  input  logic sin_q,
  input  logic sin_qn,
  output logic data_bit,
  output logic bad
);

  assign data_bit = sin_q;
  assign bad      = sin_en & (sin_q == sin_qn);

endmodule

// File: rtl/usr_serial_receiver.sv
// Serial receive endpoint: assembles LSB-first dual-rail bits into words on a valid/ready port.
module usr_serial_receiver
  import usr_pkg::*;
#(
  parameter int WIDTH = USR_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin_en,
  input  logic             sin_q,
  input  logic             sin_qn,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             rail_err,
  output logic             overrun,
  input  logic             err_clr
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  rx_state_t        state_r;
  logic [CW-1:0]    count_r;
  logic [WIDTH-1:0] shift_r;
  logic [WIDTH-1:0] out_data_r;
  logic             out_valid_r;
  logic             rail_err_r;
  logic             overrun_r;

  logic             bit_s;
  logic             bad_s;
  logic             good_s;
  logic             complete_s;
  logic             consume_s;
  logic             ovr_set_s;
  logic [WIDTH-1:0] word_s;

  dual_rail_sampler u_sampler (
    .sin_en   (sin_en),
    .sin_q    (sin_q),
    .sin_qn   (sin_qn),
    .data_bit (bit_s),
    .bad      (bad_s)
  );

  // Next-word assembly and handshake decode.
  always_comb begin
    good_s     = sin_en & ~bad_s;
    complete_s = good_s & (count_r == LAST);
    consume_s  = out_valid_r & out_ready;
    ovr_set_s  = complete_s & out_valid_r & ~out_ready;
    word_s     = shift_r | (WIDTH'(bit_s) << count_r);
  end

  // Receive FSM, output holding register and sticky error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      count_r     <= {CW{1'b0}};
      shift_r     <= {WIDTH{1'b0}};
      out_data_r  <= {WIDTH{1'b0}};
      out_valid_r <= 1'b0;
      rail_err_r  <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (good_s) begin
            shift_r <= word_s;
            count_r <= CW'(1);
            state_r <= SHIFT;
          end
        end
        SHIFT: begin
          // Shift bits are cleared on exit so the next word can be OR-assembled.
          if (bad_s || complete_s) begin
            shift_r <= {WIDTH{1'b0}};
            count_r <= {CW{1'b0}};
            state_r <= IDLE;
          end else if (good_s) begin
            shift_r <= word_s;
            count_r <= count_r + CW'(1);
          end
        end
        default: begin
          shift_r <= {WIDTH{1'b0}};
          count_r <= {CW{1'b0}};
          state_r <= IDLE;
        end
      endcase

      if (complete_s && !ovr_set_s) begin
        out_data_r  <= word_s;
        out_valid_r <= 1'b1;
      end else if (consume_s) begin
        out_valid_r <= 1'b0;
      end

      rail_err_r <= bad_s | (rail_err_r & ~err_clr);
      overrun_r  <= ovr_set_s | (overrun_r & ~err_clr);
    end
  end

  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;
  assign rail_err  = rail_err_r;
  assign overrun   = overrun_r;

endmodule

// File: doc/usr_serial_receiver.md
# usr_serial_receiver

Receive-side endpoint for the serial output of the reversible universal shift register. It samples the register's dual-rail serial output (true rail and complement rail, as produced by the reversible D flip-flops) one bit per strobe and checks rail complementarity. It assembles WIDTH-bit words LSB-first and presents each word on a valid/ready output port. It sits between the shift-register chain and downstream checking/capture logic, and is the counterpart of the block that loads and shifts data out.

## Interface
Parameters:
- WIDTH, 4, word length in bits; legal range 2..32.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous and active-high.
- sin_en  input  1  shift strobe; one serial bit is presented per cycle while high.
- sin_q  input  1  serial data, true rail.
- sin_qn  input  1  serial data, complement rail.
- out_data  output  WIDTH  assembled word; bit 0 is the first bit received.
- out_valid  output  1  out_data holds an unconsumed word.
- out_ready  input  1  consumer accepts the word on any edge where out_valid && out_ready.
- rail_err  output  1  sticky flag: a sampled bit had sin_q == sin_qn.
- overrun  output  1  sticky flag: a completed word was dropped because the output was still full.
- err_clr  input  1  synchronous clear of rail_err and overrun.

## Operation
- Reset values: out_data=0, out_valid=0, rail_err=0, overrun=0, internal shift register=0, bit count=0, FSM=IDLE.
- FSM states:
  - IDLE: count=0. sin_en moves to SHIFT.
  - SHIFT: 0<count<WIDTH. Returns to IDLE on word completion or a rail error.
- Bit acceptance: on each edge with sin_en=1:
  - If sin_q != sin_qn, sin_q is shifted in at position count and count increments.
  - If sin_q == sin_qn, the bit is invalid: rail_err is set, the partial word is discarded (count reset to 0), and the FSM goes to IDLE.
- Word completion: on the edge where the WIDTH-th valid bit is accepted:
  - If out_valid=0, or out_ready=1 on that same edge, out_data is loaded with the full word and out_valid is set to 1.
  - Otherwise the word is dropped, overrun is set, and out_data is unchanged.
  - In all three cases count returns to 0.
- Consumption: an edge with out_valid && out_ready and no simultaneous completion clears out_valid. out_data holds its last value.
- Simultaneous completion and consumption: the new word replaces the old one, out_valid stays 1, and overrun is not set.
- err_clr clears both sticky flags. If a new error occurs on the same edge, the set wins.
- sin_en=0 holds all receive state. There is no timeout, so partial words persist indefinitely.
- An asynchronous rst in the middle of a word discards the partial word and any pending output immediately.

## Timing
- Latency: out_data and out_valid update at the same rising edge that samples the last bit. They are visible in the cycle after that edge.
- Back-to-back words at full rate (sin_en held at 1) need out_ready=1 on every completion edge to avoid overrun.
- rail_err and overrun are asserted in the cycle after the offending edge.
- There are no combinational paths from inputs to outputs. out_valid is not a function of out_ready within the same cycle.

## Structure
- Shared package usr_pkg holds:
  - state enum rx_state_t {IDLE, SHIFT}.
  - USR_WIDTH_DEFAULT=4.
  - The log2 helper used for the count width ($clog2(WIDTH+1)).
- One sub-module, dual_rail_sampler: it registers nothing and outputs bit=sin_q and bad=sin_en&&(sin_q==sin_qn). It is shared with other dual-rail consumers in the register datapath.
- Top level contains the FSM, the shift register and counter, the output holding register and the sticky flags.

## Test plan
- Reset, then with WIDTH=4 send valid bits 1,0,1,1 on four consecutive sin_en cycles with out_ready=0. Required: out_valid=1 and out_data=4'b1101 after the 4th edge. Then raise out_ready for one cycle: out_valid=0.
- During the 2nd bit drive sin_q=sin_qn=1. Required: rail_err=1, partial word discarded. Then send 0,1,1,0: out_data=4'b0110. Then pulse err_clr: rail_err=0.
- With out_ready=0, send two full words 4'hA and 4'h5. Required: out_data stays 4'hA and overrun=1.
- Stream words 4'h3 then 4'hC continuously with out_ready high only on the 2nd completion edge. Required: out_data=4'hC, out_valid stays 1, overrun=0.
- Pulse rst asynchronously after 2 bits. Required: all outputs are 0 immediately. Then a fresh 4-bit word 4'h9 is received correctly.
- Send bits with sin_en gapped (e.g. 1 cycle on, 3 off). Required: the word is unchanged and out_valid is not asserted before the 4th accepted bit.
